nibble_serial_adder: RTL

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

---
 rtl/nibble_serial_adder.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: one shared 4-bit carry-lookahead slice adds one nibble
// of the captured operands per cycle. The result is presented through a
// valid/ready handshake together with the carry out and the signed overflow.

// 4-bit carry-lookahead adder slice.
module cla_4bit (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       c_i,
   output logic [3:0] s_o,
   output logic       c_o
);
   logic [3:0] g_s;
   logic [3:0] p_s;
   logic [4:0] c_s;

   // Generate/propagate terms and flattened lookahead carries.
   always_comb begin
      g_s    = a_i & b_i;
      p_s    = a_i ^ b_i;
      c_s[0] = c_i;
      c_s[1] = g_s[0] | (p_s[0] & c_i);
      c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & c_i);
      c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
             | (p_s[2] & p_s[1] & p_s[0] & c_i);
      c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
             | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
             | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & c_i);
      s_o    = p_s ^ c_s[3:0];
      c_o    = c_s[4];
   end
endmodule

module nibble_serial_adder #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [4*NIBBLES-1:0] a,
   input  logic [4*NIBBLES-1:0] b,
   input  logic                 cin,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [4*NIBBLES-1:0] sum,
   output logic                 cout,
   output logic                 overflow,
   output logic                 busy
);
   localparam int W  = 4 * NIBBLES;
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic            carry_q, carry_d;
   logic [W-1:0]    sum_q, sum_d;
   logic            cout_q, cout_d;
   logic            ovf_q, ovf_d;
   logic [3:0]      cla_s_s;
   logic            cla_c_s;
   logic            last_s;

   assign last_s = (idx_q == IDX_LAST);

   cla_4bit u_cla (
      .a_i (a_q[4*idx_q +: 4]),
      .b_i (b_q[4*idx_q +: 4]),
      .c_i (carry_q),
      .s_o (cla_s_s),
      .c_o (cla_c_s)
   );

   // State register; reset aborts any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid) state_d = RUN;  else state_d = IDLE;
         RUN:     if (last_s)   state_d = DONE; else state_d = RUN;
         DONE:    if (out_ready) state_d = IDLE; else state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   // Handshake and status outputs decoded from the state register.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state_q)
         IDLE:    in_ready  = 1'b1;
         RUN:     busy      = 1'b1;
         DONE:    begin out_valid = 1'b1; busy = 1'b1; end
         default: in_ready  = 1'b0;
      endcase
   end

   // Datapath next-state: capture on accept, one nibble per RUN cycle.
   always_comb begin
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               idx_d   = '0;
               sum_d   = '0;
            end else begin
               idx_d   = idx_q;
            end
         end
         RUN: begin
            sum_d[4*idx_q +: 4] = cla_s_s;
            carry_d             = cla_c_s;
            if (last_s) begin
               idx_d  = '0;
               cout_d = cla_c_s;
               // The top nibble's sum bit 3 is the final sign bit.
               ovf_d  = (a_q[W-1] == b_q[W-1]) & (cla_s_s[3] != a_q[W-1]);
            end else begin
               idx_d  = idx_q + IW'(1);
            end
         end
         default: idx_d = idx_q;
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign sum      = sum_q;
   assign cout     = cout_q;
   assign overflow = ovf_q;
endmodule
